core_ctrl_unit: RTL and testbench
=================================

Name: core_ctrl_unit

Overview:
- Multi-cycle control sequencer for one processor core's register-file datapath: fetch, decode and execute.
- Drives every register write/read strobe, the ALU operand loads, the clears, the increments and the ALU mux select.
- Obtains data-memory access through the shared-memory arbiter with a DMREQ/DMGNT handshake.
- One instance per core, sitting beside the core's register file.

Parameters:
HALT_ON_ILLEGAL, 1, 1 = illegal instruction sets ILLEGAL and halts; 0 = illegal instruction sets ILLEGAL and executes as NOP.
IW, 16, instruction width; must equal the register-file data width.

Ports:
clk  in  1  core clock; all state changes on rising edge
RSTN  in  1  asynchronous active-low reset
START  in  1  level; run request from the host
IROUT  in  16  IR contents from the register file
ZFLAG  in  1  ALU zero flag, sampled in EXEC1
DMGNT  in  1  data-memory grant from the arbiter
WREG  out  12  write strobes, bits 0..11 = AR,DR,PC,IR,R1..R7,AC
RREG  out  12  bus-source read strobes, same ordering as WREG; at most one bit high
LDALU  out  6  bits 0..5 = IR,IDX,IDY,R1,R5,AC
RSTR  out  7  clear strobes, bits 0..6 = R1..R7
R2INC, PCINC  out  1 each  increment strobes
ALUMUX  out  3  ALU operand select
MEMREAD  out  1  selects data memory onto the write bus
DMREQ, DMWRITE  out  1 each  memory request; write enable
DONE, ILLEGAL  out  1 each  halted; sticky illegal-instruction flag

Behaviour:
- Reset: state goes to IDLE, instruction latch is cleared, ILLEGAL is cleared, all outputs are 0 immediately.
- Reset mid-instruction aborts the instruction with no partial strobes.
- Outputs are decoded combinationally from the state register and the latched fields only.
- Instruction fields: OP = IR[15:12], D = IR[11:8], S = IR[7:4].
- Register codes for D and S: 0 AR, 1 DR, 2 PC, 3 IR, 4..10 R1..R7, 11 AC. Codes 12..15 are illegal.
- IDLE: no strobes. Go to FETCH when START = 1.
- FETCH (1 cycle): WREG[IR] = 1 and PCINC = 1. IR captures the instruction at the old PC while PC increments.
- DECODE (1 cycle): latch OP, D and S from IROUT; no strobes.
- From DECODE:
  - OP 0 NOP → FETCH.
  - OP 1 MOV → EXEC1: RREG[S] = 1, WREG[D] = 1.
  - OP 2 ALU, with sel = S[2:0] where 0 IR, 1 R5, 2 R1, 3 IDX, 4 IDY:
    - EXEC1: ALUMUX = sel, matching LDALU bit = 1.
    - EXEC2: ALUMUX = sel held, LDALU[AC] = 1.
    - sel > 4 or S[3] = 1 is illegal.
  - OP 3 LOAD and OP 4 STORE → MEMWAIT.
  - OP 5 CLR → EXEC1: RSTR[D-4] = 1. D outside 4..10 is illegal.
  - OP 6 INC2 → EXEC1: R2INC = 1.
  - OP 7 JMPZ → EXEC1: if ZFLAG = 1, RREG[S] = 1 and WREG[PC] = 1; otherwise no strobe.
  - OP 15 HALT → HALT.
  - OP 8..14 are illegal.
- MEMWAIT: DMREQ = 1, held until DMGNT is sampled 1, then go to MEMACC. No timeout. START is ignored.
- MEMACC (1 cycle), DMREQ stays 1:
  - LOAD: MEMREAD = 1, WREG[DR] = 1.
  - STORE: DMWRITE = 1. DOUT already holds DR.
  - Then go to FETCH; DMREQ drops.
- DMGNT outside MEMWAIT/MEMACC is ignored.
- After the final EXEC1/EXEC2/MEMACC cycle → FETCH.
- Instruction cycle counts, including FETCH and DECODE: NOP 2; MOV, CLR, INC2, JMPZ 3; ALU 4; LOAD/STORE 3 + wait cycles.
- HALT: DONE = 1, no strobes. Go to IDLE when START = 0.
- Illegal instruction: ILLEGAL set at DECODE and stays set until reset. Then HALT if HALT_ON_ILLEGAL = 1, else FETCH.
- START dropping outside IDLE/HALT has no effect; the program runs until HALT.
- Invariants: RREG is one-hot or zero; WREG never has more than one bit set.

Test Plan:
- Reset/boot: RSTN low mid-MEMWAIT → all outputs 0 in the same cycle. Release with START = 1 → FETCH strobes (WIR, PCINC) on the 1st edge, DECODE on the 2nd.
- MOV: IROUT = 16'h1B40 (AC ← R1) → EXEC1 has RREG = 12'h010 and WREG = 12'h800 for exactly 1 cycle, then FETCH.
- ALU: IROUT = 16'h2040 (IDY) → EXEC1 ALUMUX = 4 with LDALU = 6'h04; EXEC2 LDALU = 6'h20; 4 cycles total.
- LOAD with arbiter delay: DMGNT held low 5 cycles → DMREQ high for 6 cycles. MEMREAD and WREG = 12'h002 high only in the final cycle.
- JMPZ: IROUT = 16'h7060 (S = R3) with ZFLAG = 0 → no strobes. With ZFLAG = 1 → RREG = 12'h040, WREG = 12'h004.
- Illegal and halt:
  - IROUT = 16'h9000 → ILLEGAL = 1, DONE = 1.
  - HALT_ON_ILLEGAL = 0 → continues to FETCH with ILLEGAL still 1.
  - After halt, START 1 → 0 → 1 returns to FETCH.

Source files
------------

// File: rtl/core_ctrl_unit_if.sv
// Data-memory handshake between a core's control sequencer and the
// shared-memory arbiter.
interface core_ctrl_unit_if;
    logic DMREQ;
    logic DMGNT;
    logic DMWRITE;
    logic MEMREAD;

    modport master (output DMREQ, output DMWRITE, output MEMREAD, input DMGNT);
    modport slave  (input DMREQ, input DMWRITE, input MEMREAD, output DMGNT);
endinterface

// File: rtl/core_ctrl_unit.sv
// Multi-cycle fetch/decode/execute sequencer for one core's register-file
// datapath. Every strobe is decoded from the state register and the
// instruction fields latched in DECODE; ZFLAG is only looked at in EXEC1.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for START
// FETCH    | IR <- mem[PC], PC incremented
// DECODE   | OP/D/S latched from IROUT, illegal encodings detected
// EXEC1    | first execute cycle (MOV, ALU load, CLR, INC2, JMPZ)
// EXEC2    | ALU result into AC
// MEMWAIT  | DMREQ raised, waiting for DMGNT
// MEMACC   | memory transfer cycle for LOAD/STORE
// HALT     | DONE raised until START drops
module core_ctrl_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int IW              = 16
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              START,
    input  logic [IW-1:0]     IROUT,
    input  logic              ZFLAG,
    core_ctrl_unit_if.master  mem,
    output logic [11:0]       WREG,
    output logic [11:0]       RREG,
    output logic [5:0]        LDALU,
    output logic [6:0]        RSTR,
    output logic              R2INC,
    output logic              PCINC,
    output logic [2:0]        ALUMUX,
    output logic              DONE,
    output logic              ILLEGAL
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC1   = 3'd3;
    localparam logic [2:0] S_EXEC2   = 3'd4;
    localparam logic [2:0] S_MEMWAIT = 3'd5;
    localparam logic [2:0] S_MEMACC  = 3'd6;
    localparam logic [2:0] S_HALT    = 3'd7;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ALU   = 4'd2;
    localparam logic [3:0] OP_LOAD  = 4'd3;
    localparam logic [3:0] OP_STORE = 4'd4;
    localparam logic [3:0] OP_CLR   = 4'd5;
    localparam logic [3:0] OP_INC2  = 4'd6;
    localparam logic [3:0] OP_JMPZ  = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // Register codes in WREG/RREG bit order
    localparam int RC_DR = 1;
    localparam int RC_PC = 2;
    localparam int RC_IR = 3;
    localparam int LD_AC = 5;

    logic [2:0] state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] dst_q, dst_d;
    logic [3:0] src_q, src_d;
    logic       illegal_q, illegal_d;

    logic [3:0] ir_op, ir_dst, ir_src;
    logic       ir_illegal;
    logic       unused_ir_low;

    logic       dmreq, dmwrite, memread;

    assign ir_op         = IROUT[15:12];
    assign ir_dst        = IROUT[11:8];
    assign ir_src        = IROUT[7:4];
    assign unused_ir_low = ^IROUT[3:0];

    // Codes 12..15 name no register, so they shift out to an all-zero strobe.
    function automatic logic [11:0] reg_onehot(input logic [3:0] code);
        return 12'd1 << code;
    endfunction

    function automatic logic [5:0] alu_ld(input logic [2:0] sel);
        case (sel)
            3'd0:    return 6'h01;   // IR
            3'd1:    return 6'h10;   // R5
            3'd2:    return 6'h08;   // R1
            3'd3:    return 6'h02;   // IDX
            3'd4:    return 6'h04;   // IDY
            default: return 6'h00;
        endcase
    endfunction

    // Encodings that would address a non-existent register or operand.
    always_comb begin
        ir_illegal = 1'b0;
        case (ir_op)
            OP_MOV:  ir_illegal = (ir_dst > 4'd11) || (ir_src > 4'd11);
            OP_ALU:  ir_illegal = ir_src[3] || (ir_src[2:0] > 3'd4);
            OP_CLR:  ir_illegal = (ir_dst < 4'd4) || (ir_dst > 4'd10);
            OP_JMPZ: ir_illegal = (ir_src > 4'd11);
            OP_NOP, OP_LOAD, OP_STORE, OP_INC2, OP_HALT: ir_illegal = 1'b0;
            default: ir_illegal = 1'b1;
        endcase
    end

    // Next-state, field latch and sticky illegal flag.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        src_d     = src_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:   if (START) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d  = ir_op;
                dst_d = ir_dst;
                src_d = ir_src;
                if (ir_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end else begin
                    case (ir_op)
                        OP_MOV, OP_ALU, OP_CLR, OP_INC2, OP_JMPZ: state_d = S_EXEC1;
                        OP_LOAD, OP_STORE:                       state_d = S_MEMWAIT;
                        OP_HALT:                                 state_d = S_HALT;
                        default:                                 state_d = S_FETCH;
                    endcase
                end
            end
            S_EXEC1:   state_d = (op_q == OP_ALU) ? S_EXEC2 : S_FETCH;
            S_EXEC2:   state_d = S_FETCH;
            S_MEMWAIT: if (mem.DMGNT) state_d = S_MEMACC;
            S_MEMACC:  state_d = S_FETCH;
            S_HALT:    if (!START) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State and latched fields; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            op_q      <= 4'd0;
            dst_q     <= 4'd0;
            src_q     <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobe decode from state and latched fields.
    always_comb begin
        WREG    = '0;
        RREG    = '0;
        LDALU   = '0;
        RSTR    = '0;
        R2INC   = 1'b0;
        PCINC   = 1'b0;
        ALUMUX  = '0;
        DONE    = 1'b0;
        dmreq   = 1'b0;
        dmwrite = 1'b0;
        memread = 1'b0;
        case (state_q)
            S_FETCH: begin
                WREG[RC_IR] = 1'b1;
                PCINC       = 1'b1;
            end
            S_EXEC1: begin
                case (op_q)
                    OP_MOV: begin
                        RREG = reg_onehot(src_q);
                        WREG = reg_onehot(dst_q);
                    end
                    OP_ALU: begin
                        ALUMUX = src_q[2:0];
                        LDALU  = alu_ld(src_q[2:0]);
                    end
                    OP_CLR:  RSTR  = 7'd1 << (dst_q - 4'd4);
                    OP_INC2: R2INC = 1'b1;
                    OP_JMPZ: begin
                        if (ZFLAG) begin
                            RREG        = reg_onehot(src_q);
                            WREG[RC_PC] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                ALUMUX       = src_q[2:0];
                LDALU[LD_AC] = 1'b1;
            end
            S_MEMWAIT: dmreq = 1'b1;
            S_MEMACC: begin
                dmreq = 1'b1;
                if (op_q == OP_LOAD) begin
                    memread     = 1'b1;
                    WREG[RC_DR] = 1'b1;
                end else begin
                    dmwrite = 1'b1;
                end
            end
            S_HALT:  DONE = 1'b1;
            default: ;
        endcase
    end

    assign mem.DMREQ   = dmreq;
    assign mem.DMWRITE = dmwrite;
    assign mem.MEMREAD = memread;
    assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_core_ctrl_unit.sv
// Directed bench for core_ctrl_unit: u0 halts on illegal opcodes, u1 treats
// them as NOP. Both see the same stimulus.
module tb_core_ctrl_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        zflag = 1'b0;
    logic        dmgnt = 1'b0;
    logic [15:0] irout = 16'h0000;

    logic [11:0] wreg0, rreg0, wreg1, rreg1;
    logic [5:0]  ldalu0, ldalu1;
    logic [6:0]  rstr0, rstr1;
    logic        r2inc0, pcinc0, done0, ill0;
    logic        r2inc1, pcinc1, done1, ill1;
    logic [2:0]  alumux0, alumux1;
    logic [46:0] all0;

    int checks = 0;
    int errors = 0;
    int cnt;

    core_ctrl_unit_if mif0();
    core_ctrl_unit_if mif1();
    assign mif0.DMGNT = dmgnt;
    assign mif1.DMGNT = dmgnt;

    core_ctrl_unit #(.HALT_ON_ILLEGAL(1'b1), .IW(16)) u0 (
        .clk(clk), .RSTN(rstn), .START(start), .IROUT(irout), .ZFLAG(zflag),
        .mem(mif0.master),
        .WREG(wreg0), .RREG(rreg0), .LDALU(ldalu0), .RSTR(rstr0),
        .R2INC(r2inc0), .PCINC(pcinc0), .ALUMUX(alumux0),
        .DONE(done0), .ILLEGAL(ill0)
    );

    core_ctrl_unit #(.HALT_ON_ILLEGAL(1'b0), .IW(16)) u1 (
        .clk(clk), .RSTN(rstn), .START(start), .IROUT(irout), .ZFLAG(zflag),
        .mem(mif1.master),
        .WREG(wreg1), .RREG(rreg1), .LDALU(ldalu1), .RSTR(rstr1),
        .R2INC(r2inc1), .PCINC(pcinc1), .ALUMUX(alumux1),
        .DONE(done1), .ILLEGAL(ill1)
    );

    assign all0 = {wreg0, rreg0, ldalu0, rstr0, r2inc0, pcinc0, alumux0,
                   mif0.MEMREAD, mif0.DMREQ, mif0.DMWRITE, done0, ill0};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        dmgnt = 1'b0;
        zflag = 1'b0;
        irout = 16'h0000;
        rstn  = 1'b0;
        tick();
        rstn  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (all0 !== 47'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected %h", all0, 47'd0);
        end
        irout = 16'h3000;
        start = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (mif0.DMREQ !== 1'b1) begin
            errors++;
            $display("FAIL memwait_dmreq got %b expected 1", mif0.DMREQ);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (all0 !== 47'd0) begin
            errors++;
            $display("FAIL reset_mid_memwait got %h expected %h", all0, 47'd0);
        end
        #1;
        rstn = 1'b1;
        tick();
        checks++;
        if ({wreg0, pcinc0} !== {12'h008, 1'b1}) begin
            errors++;
            $display("FAIL boot_fetch got %h/%b expected 008/1", wreg0, pcinc0);
        end
        tick();
        checks++;
        if ({wreg0, pcinc0, mif0.DMREQ} !== {12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL boot_decode got %h/%b/%b expected 000/0/0", wreg0, pcinc0, mif0.DMREQ);
        end
    endtask

    task automatic test_mov();
        do_reset();
        irout = 16'h1B40;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({rreg0, wreg0} !== {12'h010, 12'h800}) begin
            errors++;
            $display("FAIL mov_exec1 got %h/%h expected 010/800", rreg0, wreg0);
        end
        tick();
        checks++;
        if ({rreg0, wreg0, pcinc0} !== {12'h000, 12'h008, 1'b1}) begin
            errors++;
            $display("FAIL mov_then_fetch got %h/%h/%b expected 000/008/1", rreg0, wreg0, pcinc0);
        end
    endtask

    task automatic test_alu();
        do_reset();
        irout = 16'h2040;
        start = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({alumux0, ldalu0} !== {3'd4, 6'h04}) begin
            errors++;
            $display("FAIL alu_idy_exec1 got %0d/%h expected 4/04", alumux0, ldalu0);
        end
        tick();
        checks++;
        if ({alumux0, ldalu0} !== {3'd4, 6'h20}) begin
            errors++;
            $display("FAIL alu_idy_exec2 got %0d/%h expected 4/20", alumux0, ldalu0);
        end
        irout = 16'h2010;
        tick();
        checks++;
        if ({wreg0, ldalu0} !== {12'h008, 6'h00}) begin
            errors++;
            $display("FAIL alu_then_fetch got %h/%h expected 008/00", wreg0, ldalu0);
        end
        tick();
        tick();
        checks++;
        if ({alumux0, ldalu0} !== {3'd1, 6'h10}) begin
            errors++;
            $display("FAIL alu_r5_exec1 got %0d/%h expected 1/10", alumux0, ldalu0);
        end
    endtask

    task automatic test_load_store();
        do_reset();
        irout = 16'h3000;
        start = 1'b1;
        tick();
        tick();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 4) dmgnt = 1'b1;
            if (mif0.DMREQ !== 1'b1) break;
            cnt++;
            checks++;
            if (cnt < 6) begin
                if ({mif0.MEMREAD, wreg0} !== {1'b0, 12'h000}) begin
                    errors++;
                    $display("FAIL load_wait_%0d got %b/%h expected 0/000", cnt, mif0.MEMREAD, wreg0);
                end
            end else begin
                if ({mif0.MEMREAD, wreg0} !== {1'b1, 12'h002}) begin
                    errors++;
                    $display("FAIL load_acc_%0d got %b/%h expected 1/002", cnt, mif0.MEMREAD, wreg0);
                end
            end
        end
        checks++;
        if (cnt != 6) begin
            errors++;
            $display("FAIL load_dmreq_cycles got %0d expected 6", cnt);
        end
        checks++;
        if (wreg0 !== 12'h008) begin
            errors++;
            $display("FAIL load_then_fetch got %h expected 008", wreg0);
        end
        irout = 16'h4000;
        tick();
        checks++;
        if (mif0.DMREQ !== 1'b0) begin
            errors++;
            $display("FAIL store_decode_dmreq got %b expected 0", mif0.DMREQ);
        end
        tick();
        checks++;
        if ({mif0.DMREQ, mif0.DMWRITE} !== 2'b10) begin
            errors++;
            $display("FAIL store_memwait got %b%b expected 10", mif0.DMREQ, mif0.DMWRITE);
        end
        tick();
        checks++;
        if ({mif0.DMREQ, mif0.DMWRITE, mif0.MEMREAD, wreg0} !== {3'b110, 12'h000}) begin
            errors++;
            $display("FAIL store_memacc got %b%b%b/%h expected 110/000",
                     mif0.DMREQ, mif0.DMWRITE, mif0.MEMREAD, wreg0);
        end
        dmgnt = 1'b0;
        tick();
        checks++;
        if ({mif0.DMREQ, wreg0} !== {1'b0, 12'h008}) begin
            errors++;
            $display("FAIL store_then_fetch got %b/%h expected 0/008", mif0.DMREQ, wreg0);
        end
    endtask

    task automatic test_jmpz();
        do_reset();
        irout = 16'h7060;
        start = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({rreg0, wreg0} !== {12'h000, 12'h000}) begin
            errors++;
            $display("FAIL jmpz_z0 got %h/%h expected 000/000", rreg0, wreg0);
        end
        tick();
        tick();
        zflag = 1'b1;
        tick();
        checks++;
        if ({rreg0, wreg0} !== {12'h040, 12'h004}) begin
            errors++;
            $display("FAIL jmpz_z1 got %h/%h expected 040/004", rreg0, wreg0);
        end
        zflag = 1'b0;
    endtask

    task automatic test_clr_inc();
        do_reset();
        irout = 16'h5A00;
        start = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (rstr0 !== 7'h40) begin
            errors++;
            $display("FAIL clr_r7 got %h expected 40", rstr0);
        end
        irout = 16'h6000;
        tick();
        tick();
        tick();
        checks++;
        if ({r2inc0, rstr0} !== {1'b1, 7'h00}) begin
            errors++;
            $display("FAIL inc2 got %b/%h expected 1/00", r2inc0, rstr0);
        end
        irout = 16'h5300;
        tick();
        tick();
        tick();
        checks++;
        if ({done0, ill0, rstr0} !== {1'b1, 1'b1, 7'h00}) begin
            errors++;
            $display("FAIL clr_bad_dst got %b%b/%h expected 11/00", done0, ill0, rstr0);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        irout = 16'h9000;
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (ill0 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_in_decode got %b expected 0", ill0);
        end
        tick();
        checks++;
        if ({ill0, done0, wreg0} !== {1'b1, 1'b1, 12'h000}) begin
            errors++;
            $display("FAIL illegal_halt got %b%b/%h expected 11/000", ill0, done0, wreg0);
        end
        checks++;
        if ({ill1, done1, wreg1} !== {1'b1, 1'b0, 12'h008}) begin
            errors++;
            $display("FAIL illegal_nop got %b%b/%h expected 10/008", ill1, done1, wreg1);
        end
        tick();
        checks++;
        if (done0 !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold got %b expected 1", done0);
        end
        start = 1'b0;
        tick();
        checks++;
        if ({done0, wreg0} !== {1'b0, 12'h000}) begin
            errors++;
            $display("FAIL halt_to_idle got %b/%h expected 0/000", done0, wreg0);
        end
        start = 1'b1;
        tick();
        checks++;
        if ({wreg0, pcinc0, ill0} !== {12'h008, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL restart_fetch got %h/%b/%b expected 008/1/1", wreg0, pcinc0, ill0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        irout = 16'h0000;
        start = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({wreg0, pcinc0} !== {12'h008, 1'b1}) begin
            errors++;
            $display("FAIL nop_2cycle got %h/%b expected 008/1", wreg0, pcinc0);
        end
        irout = 16'hF000;
        tick();
        tick();
        checks++;
        if ({done0, ill0} !== 2'b10) begin
            errors++;
            $display("FAIL halt_op got %b%b expected 10", done0, ill0);
        end
        start = 1'b0;
        tick();
        tick();
        checks++;
        if ({done0, wreg0} !== {1'b0, 12'h000}) begin
            errors++;
            $display("FAIL idle_wait got %b/%h expected 0/000", done0, wreg0);
        end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_alu();
        test_load_store();
        test_jmpz();
        test_clr_inc();
        test_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
